// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO push arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
    localparam int BURST = 3;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index after last_grant, wrapping at N_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = fifo_arb_pkg::N_REQ,
    parameter int IDW   = idx_bits(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   last_grant_i,
    output logic [IDW-1:0]   winner_o,
    output logic             any_valid_o
);

    int idx;

    always_comb begin
        winner_o    = last_grant_i;
        any_valid_o = 1'b0;
        idx         = 0;
        // Scan offsets 1..N_REQ so last_grant itself is considered last.
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_grant_i) + i) % N_REQ;
            if (!any_valid_o && req_i[idx]) begin
                any_valid_o = 1'b1;
                winner_o    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Grants whole BURST-word records from N_REQ streams into one FIFO push port, round-robin,
// only when the FIFO has room for a complete record.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = fifo_arb_pkg::N_REQ,
    parameter int WIDTH = fifo_arb_pkg::WIDTH,
    parameter int DEPTH = fifo_arb_pkg::DEPTH,
    parameter int BURST = fifo_arb_pkg::BURST,
    parameter int IDW   = idx_bits(N_REQ),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic                        CLK_IN,
    input  logic                        RESET_IN,
    input  logic [N_REQ-1:0][WIDTH-1:0] REQ_DIN,
    input  logic [N_REQ-1:0]            REQ_VALID,
    output logic [N_REQ-1:0]            REQ_READY,
    output logic [WIDTH-1:0]            FIFO_DIN,
    output logic                        FIFO_DIN_VALID,
    input  logic                        FIFO_DIN_READY,
    input  logic [LW-1:0]               FIFO_LEVEL,
    output logic [IDW-1:0]              GRANT_ID,
    output logic                        BUSY,
    output logic                        BURST_DONE
);

    localparam int CW = idx_bits(BURST);

    // Handshake contract: a word moves on a rising edge where the granted REQ_VALID and
    // FIFO_DIN_READY are both high; REQ_READY mirrors FIFO_DIN_READY only for the owner.

    arb_state_e     state_q;
    logic [IDW-1:0] grant_q;
    logic [IDW-1:0] last_grant_q;
    logic [CW-1:0]  word_cnt_q;
    logic [CW-1:0]  word_cnt_d;

    logic [IDW-1:0] winner;
    logic           any_valid;
    logic [LW:0]    space;
    logic           space_ok;
    logic           handshake;
    logic           last_word;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req_i        (REQ_VALID),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_valid_o  (any_valid)
    );

    // One extra bit so an over-reported level shows up as negative space, never a wrap.
    assign space    = (LW+1)'(DEPTH) - {1'b0, FIFO_LEVEL};
    assign space_ok = !space[LW] && (space >= (LW+1)'(BURST));

    assign handshake  = (state_q == XFER) && REQ_VALID[grant_q] && FIFO_DIN_READY;
    assign last_word  = (word_cnt_q == CW'(BURST - 1));
    assign word_cnt_d = word_cnt_q + CW'(1);

    always_comb begin
        REQ_READY      = '0;
        FIFO_DIN_VALID = 1'b0;
        FIFO_DIN       = REQ_DIN[grant_q];
        if (state_q == XFER) begin
            FIFO_DIN_VALID     = REQ_VALID[grant_q];
            REQ_READY[grant_q] = FIFO_DIN_READY;
        end
    end

    assign BURST_DONE = handshake && last_word;
    assign BUSY       = (state_q == XFER);
    assign GRANT_ID   = grant_q;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(N_REQ - 1);
            word_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid && space_ok) begin
                        state_q      <= XFER;
                        grant_q      <= winner;
                        last_grant_q <= winner;
                        word_cnt_q   <= '0;
                    end
                end
                XFER: begin
                    if (handshake) begin
                        if (last_word) begin
                            state_q    <= IDLE;
                            word_cnt_q <= '0;
                        end else begin
                            word_cnt_q <= word_cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: quota-driven requester streams, word and grant scoreboards.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int LW = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0][W-1:0] req_din;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [W-1:0]      fifo_din;
    logic              fifo_din_valid;
    logic              fifo_din_ready;
    logic [LW-1:0]     fifo_level;
    logic [1:0]        grant_id;
    logic              busy;
    logic              burst_done;

    fifo_push_arbiter dut (
        .CLK_IN         (clk),
        .RESET_IN       (rst),
        .REQ_DIN        (req_din),
        .REQ_VALID      (req_valid),
        .REQ_READY      (req_ready),
        .FIFO_DIN       (fifo_din),
        .FIFO_DIN_VALID (fifo_din_valid),
        .FIFO_DIN_READY (fifo_din_ready),
        .FIFO_LEVEL     (fifo_level),
        .GRANT_ID       (grant_id),
        .BUSY           (busy),
        .BURST_DONE     (burst_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- requester model ----------------
    int          ptr  [N];
    int          left [N];
    logic [7:0]  base [N];
    logic [N-1:0] pend = '0;

    function automatic logic [W-1:0] word_of(input int r, input int p);
        return W'(r * 16'h1000) + W'(base[r]) + W'(p);
    endfunction

    task automatic refresh();
        for (int r = 0; r < N; r++) begin
            req_valid[r] = (left[r] > 0);
            req_din[r]   = word_of(r, ptr[r]);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_g[$];
    int           done_cyc[$];
    int           done_cnt = 0;
    logic         busy_prev = 1'b0;

    task automatic expect_burst(input int r, input int first, input int n);
        exp_g.push_back(2'(r));
        for (int k = 0; k < n; k++) exp_q.push_back(word_of(r, first + k));
    endtask

    always @(negedge clk) begin
        cycle++;
        if (!rst) begin
            pend = req_valid & req_ready;
            if (fifo_din_valid && fifo_din_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", 32'(fifo_din), 32'hffff_ffff);
                else check("fifo_word", 32'(fifo_din), 32'(exp_q.pop_front()));
            end
            if (busy && !busy_prev) begin
                if (exp_g.size() == 0) check("unexpected_grant", 32'(grant_id), 32'hffff_ffff);
                else check("grant_id", 32'(grant_id), 32'(exp_g.pop_front()));
            end
            if (burst_done) begin
                done_cnt++;
                done_cyc.push_back(cycle);
            end
        end
        busy_prev = busy;
    end

    always @(posedge clk) begin
        #1;
        for (int r = 0; r < N; r++) begin
            if (pend[r]) begin
                ptr[r]++;
                left[r]--;
            end
        end
        pend = '0;
        refresh();
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        for (int r = 0; r < N; r++) begin
            ptr[r] = 0;
            left[r] = 0;
        end
        refresh();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        busy_prev = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
        @(negedge clk);
        check(tag, 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_ptr(input int r, input int value, input int budget);
        for (int i = 0; i < budget && ptr[r] != value; i++) begin
            @(posedge clk); #2;
        end
        check("wait_ptr", 32'(ptr[r]), 32'(value));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int r = 0; r < N; r++) begin
            base[r] = 8'($urandom_range(0, 200));
            ptr[r] = 0;
            left[r] = 0;
        end
        refresh();
        fifo_din_ready = 1'b1;
        fifo_level     = '0;

        do_reset();
        @(negedge clk);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(burst_done), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_fvalid", 32'(fifo_din_valid), 0);

        // Two requesters, 0 wins first, then 2.
        @(posedge clk); #2;
        left[0] = 3; left[2] = 3;
        expect_burst(0, 0, 3);
        expect_burst(2, 0, 3);
        refresh();
        wait_done("t035_bursts", 2, 40);

        // Everyone valid: 0,1,2,3,0 with one idle cycle between records.
        do_reset();
        done_cnt = 0;
        done_cyc.delete();
        @(posedge clk); #2;
        left[0] = 6; left[1] = 3; left[2] = 3; left[3] = 3;
        expect_burst(0, 0, 3);
        expect_burst(1, 0, 3);
        expect_burst(2, 0, 3);
        expect_burst(3, 0, 3);
        expect_burst(0, 3, 3);
        refresh();
        wait_done("t036_bursts", 5, 60);
        for (int k = 1; k < done_cyc.size(); k++)
            check("t036_gap", 32'(done_cyc[k] - done_cyc[k-1]), 4);

        // Space of 2 blocks a 3-word record; 3 is enough.
        do_reset();
        done_cnt = 0;
        fifo_level = 9'd254;
        @(posedge clk); #2;
        left[1] = 3;
        refresh();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t037_idle_busy", 32'(busy), 0);
        check("t037_idle_ready", 32'(req_ready), 0);
        check("t037_idle_fvalid", 32'(fifo_din_valid), 0);
        expect_burst(1, 0, 3);
        @(posedge clk); #2;
        fifo_level = 9'd253;
        wait_done("t037_burst", 1, 20);

        // FIFO stalls after the first word; the record resumes without extra words.
        fifo_level = '0;
        done_cnt = 0;
        @(posedge clk); #2;
        left[2] = 3;
        expect_burst(2, 0, 3);
        refresh();
        wait_ptr(2, 1, 20);
        fifo_din_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t038_stall_ready", 32'(req_ready), 0);
            check("t038_stall_busy", 32'(busy), 1);
        end
        check("t038_stall_ptr", 32'(ptr[2]), 1);
        @(posedge clk); #2;
        fifo_din_ready = 1'b1;
        wait_done("t038_burst", 1, 20);
        check("t038_words", 32'(ptr[2]), 3);

        // Reset mid-burst: outputs clear at once, requester 3 restarts its record.
        do_reset();
        done_cnt = 0;
        @(posedge clk); #2;
        left[3] = 3;
        expect_burst(3, 0, 2);
        refresh();
        wait_ptr(3, 2, 20);
        rst = 1'b1;
        #1;
        check("t039_rst_busy", 32'(busy), 0);
        check("t039_rst_grant", 32'(grant_id), 0);
        check("t039_rst_ready", 32'(req_ready), 0);
        check("t039_rst_fvalid", 32'(fifo_din_valid), 0);
        check("t039_rst_done", 32'(burst_done), 0);
        ptr[3] = 0;
        left[3] = 0;
        refresh();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        busy_prev = 1'b0;
        check("t039_aborted_done", 32'(done_cnt), 0);
        expect_burst(3, 0, 3);
        left[3] = 3;
        refresh();
        wait_done("t039_burst", 1, 20);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("words_left", 32'(exp_q.size()), 0);
        check("grants_left", 32'(exp_g.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requester streams.
REQ-002 SHALL have parameter WIDTH, default 16, data word width.
REQ-003 SHALL have parameter DEPTH, default 256, capacity of the downstream FIFO.
REQ-004 SHALL have parameter BURST, default 3, words per granted record (x,y,z).
REQ-005 SHALL have port CLK_IN, input, 1, the single clock.
REQ-006 SHALL have port RESET_IN, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port REQ_DIN, input, N_REQ x WIDTH, per-requester data.
REQ-008 SHALL have port REQ_VALID, input, N_REQ, per-requester word valid.
REQ-009 SHALL have port REQ_READY, output, N_REQ, per-requester word accepted.
REQ-010 SHALL have port FIFO_DIN, output, WIDTH, data to the FIFO push side.
REQ-011 SHALL have port FIFO_DIN_VALID, output, 1, push valid.
REQ-012 SHALL have port FIFO_DIN_READY, input, 1, FIFO push ready.
REQ-013 SHALL have port FIFO_LEVEL, input, clog2(DEPTH)+1, FIFO occupancy.
REQ-014 SHALL have port GRANT_ID, output, clog2(N_REQ), current owner.
REQ-015 SHALL have port BUSY, output, 1, high in XFER.
REQ-016 SHALL have port BURST_DONE, output, 1, one-cycle pulse on the last word of a burst.

Function
REQ-017 SHALL implement an FSM with two states: IDLE and XFER.
REQ-018 In IDLE, SHALL grant when any REQ_VALID is high and (DEPTH - FIFO_LEVEL) >= BURST, computed at clog2(DEPTH)+2 bits so nothing wraps.
REQ-019 SHALL select the winner round-robin: the first valid index after last_grant, modulo N_REQ.
REQ-020 On a grant, SHALL register GRANT_ID, set last_grant to the winner, clear word_cnt and enter XFER on the next edge, giving 1-cycle arbitration latency.
REQ-021 In XFER, SHALL drive FIFO_DIN = REQ_DIN[GRANT_ID] and FIFO_DIN_VALID = REQ_VALID[GRANT_ID], combinationally.
REQ-022 In XFER, SHALL set REQ_READY[GRANT_ID] = FIFO_DIN_READY and hold every other REQ_READY bit low.
REQ-023 In IDLE, SHALL hold all REQ_READY bits and FIFO_DIN_VALID low.
REQ-024 SHALL count a word only on the handshake REQ_VALID[GRANT_ID] && FIFO_DIN_READY; word_cnt spans 0..BURST-1.
REQ-025 On the handshake with word_cnt == BURST-1, SHALL pulse BURST_DONE in that same cycle and return to IDLE on the next edge.
REQ-026 An idle owner or a stalled FIFO SHALL hold XFER indefinitely, with no timeout and no re-arbitration mid-burst.
REQ-027 SHALL never drop, duplicate or interleave words: each burst carries exactly BURST consecutive words from one requester.
REQ-028 With no valid requester, or insufficient space, SHALL stay in IDLE with GRANT_ID unchanged.
REQ-029 Changes to REQ_VALID on non-granted requesters SHALL have no effect during XFER.

Reset
REQ-030 Asserting RESET_IN at any time, including mid-burst, SHALL immediately force IDLE, word_cnt = 0, GRANT_ID = 0, BUSY = 0, BURST_DONE = 0, all REQ_READY = 0 and FIFO_DIN_VALID = 0.
REQ-031 On reset, SHALL set last_grant to N_REQ-1, so requester 0 wins first.
REQ-032 A partial burst aborted by reset SHALL NOT be resumed; requesters restart their record.

Structure
REQ-033 A shared package fifo_arb_pkg SHALL hold the state enum (IDLE, XFER) and the default constants N_REQ, WIDTH, DEPTH and BURST.
REQ-034 The round-robin selection SHALL be a combinational sub-module rr_pick: inputs are the request vector and last_grant; outputs are winner index and any_valid.

Verification
REQ-035 Reset then REQ_VALID = 4'b0101, FIFO_LEVEL = 0, ready = 1 -> requester 0 gets 3 words; then requester 2 gets 3 words; BURST_DONE pulses twice.
REQ-036 All 4 requesters continuously valid -> grant order 0,1,2,3,0; FIFO receives 15 words in 5 bursts of 3 with a 1-cycle IDLE gap between bursts.
REQ-037 FIFO_LEVEL = 254 (space 2 < 3) with requester 1 valid -> stays IDLE, all REQ_READY = 0; set FIFO_LEVEL = 253 -> grant to requester 1.
REQ-038 FIFO_DIN_READY low for 5 cycles after word 1 of a burst -> REQ_READY low, word_cnt holds at 1, burst completes after ready returns, no extra words.
REQ-039 Assert RESET_IN after word 2 of a requester-3 burst -> outputs go to reset values that cycle; after release, REQ_VALID = 4'b1000 -> fresh 3-word burst to requester 3.
REQ-040 Scoreboard on all runs -> FIFO word sequence equals the concatenation of per-requester streams in grant order, never interleaved.
